// File: rtl/alu_op_sequencer.sv
// Initiator-side controller for the clock-gated 8-bit registered ALU: takes a request,
// gates the ALU clock on for two cycles, then collects Result/Carry/Zero as a response.
module alu_op_sequencer #(
  parameter int DW    = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [DW-1:0]    req_a,
  input  logic [DW-1:0]    req_b,
  input  logic [2:0]       req_opcode,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [DW-1:0]    rsp_result,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [DW-1:0]    alu_a,
  output logic [DW-1:0]    alu_b,
  output logic [2:0]       alu_opcode,
  output logic             alu_clk_en,
  input  logic [DW-1:0]    alu_result,
  input  logic             alu_carry,
  input  logic             alu_zero,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_RESP    = 3'd4;

  logic [2:0]       r_state;
  logic [2:0]       w_next;
  logic [DW-1:0]    r_a;
  logic [DW-1:0]    r_b;
  logic [2:0]       r_op;
  logic [DW-1:0]    r_result;
  logic             r_carry;
  logic             r_zero;
  logic             r_err;
  logic [CNT_W-1:0] r_count;
  logic             w_accept;
  logic             w_rsp_hs;
  logic             w_carry_op;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
  endfunction

  assign req_ready  = (r_state == S_IDLE) || ((r_state == S_RESP) && rsp_ready);
  assign rsp_valid  = (r_state == S_RESP);
  assign alu_clk_en = (r_state == S_ISSUE) || (r_state == S_WAIT);

  assign w_accept   = req_valid && req_ready;
  assign w_rsp_hs   = rsp_valid && rsp_ready;
  // Only add/sub define Carry; the ALU leaves a stale value on every other opcode.
  assign w_carry_op = (r_op == 3'b000) || (r_op == 3'b001);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (req_valid) w_next = S_ISSUE;
      S_ISSUE:   w_next = S_WAIT;
      S_WAIT:    w_next = S_CAPTURE;
      S_CAPTURE: w_next = S_RESP;
      S_RESP:    if (rsp_ready) w_next = req_valid ? S_ISSUE : S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b0;
      r_err    <= 1'b0;
      r_count  <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_a  <= req_a;
        r_b  <= req_b;
        r_op <= req_opcode;
      end
      if (r_state == S_WAIT) begin
        r_result <= alu_result;
        r_carry  <= alu_carry & w_carry_op;
      end
      // Zero lags Result by one ALU clock, so it is only valid one cycle later.
      if (r_state == S_CAPTURE) begin
        r_zero <= alu_zero;
        r_err  <= alu_zero ^ (r_result == '0);
      end
      if (w_rsp_hs) r_count <= sat_inc(r_count);
    end
  end

  assign alu_a      = r_a;
  assign alu_b      = r_b;
  assign alu_opcode = r_op;
  assign rsp_result = r_result;
  assign rsp_carry  = r_carry;
  assign rsp_zero   = r_zero;
  assign rsp_err    = r_err;
  assign op_count   = r_count;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: registered ALU model, cycle-level reference model,
// directed literal checks and a randomized phase.
module tb_alu_op_sequencer;
  localparam int DW = 8;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic req_valid = 1'b0, req_ready;
  logic [DW-1:0] req_a = '0, req_b = '0;
  logic [2:0] req_opcode = '0;
  logic rsp_valid, rsp_ready = 1'b1;
  logic [DW-1:0] rsp_result;
  logic rsp_carry, rsp_zero, rsp_err;
  logic [DW-1:0] alu_a, alu_b;
  logic [2:0] alu_opcode;
  logic alu_clk_en;
  logic [DW-1:0] alu_result;
  logic alu_carry, alu_zero;
  logic [CW-1:0] op_count;

  always #5 clk = ~clk;

  alu_op_sequencer #(.DW(DW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_opcode(req_opcode),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_clk_en(alu_clk_en),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .op_count(op_count)
  );

  int checks = 0;
  int failures = 0;
  logic chk_en = 1'b0;
  logic zero_bad = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW:0] alu_f(input logic [DW-1:0] a, b, input logic [2:0] op);
    case (op)
      3'b000: return {1'b0, a} + {1'b0, b};
      3'b001: return {(a < b), a - b};
      3'b010: return {1'b0, a & b};
      3'b011: return {1'b0, a | b};
      3'b100: return {1'b0, a ^ b};
      3'b101: return {1'b0, a << b[2:0]};
      3'b110: return {1'b0, a >> b[2:0]};
      default: return {1'b0, 7'd0, (a == b)};
    endcase
  endfunction

  // Registered ALU behind a clock gate; Zero reflects the previous Result.
  logic [DW-1:0] q_res = '0;
  logic q_car = 1'b0, q_zero = 1'b0;
  logic [DW:0] w_f;
  assign w_f = alu_f(alu_a, alu_b, alu_opcode);
  always @(posedge clk) begin
    if (alu_clk_en) begin
      q_res  <= w_f[DW-1:0];
      q_zero <= (q_res == '0);
      if (alu_opcode <= 3'b001) q_car <= w_f[DW];
    end
  end
  assign alu_result = q_res;
  assign alu_carry  = q_car;
  assign alu_zero   = zero_bad ? 1'b0 : q_zero;

  // Reference: age counts cycles since acceptance (-1 idle, 1..3 in flight, 4 responding).
  typedef struct packed {
    logic [DW-1:0] res;
    logic car, zero, err;
  } rsp_t;

  function automatic rsp_t golden(input logic [DW-1:0] a, b, input logic [2:0] op, input logic bad);
    rsp_t r;
    logic [DW:0] f;
    f = alu_f(a, b, op);
    r.res  = f[DW-1:0];
    r.car  = (op <= 3'b001) ? f[DW] : 1'b0;
    r.zero = bad ? 1'b0 : (r.res == '0);
    r.err  = r.zero ^ (r.res == '0);
    return r;
  endfunction

  int age = -1;
  int m_cnt = 0;
  logic [DW-1:0] m_a = '0, m_b = '0;
  logic [2:0] m_op = '0;
  rsp_t m_rsp = '0;
  logic m_ready;
  assign m_ready = (age < 0) || (age >= 4 && rsp_ready);

  always @(posedge clk) begin
    if (!reset) begin
      age <= -1; m_cnt <= 0; m_a <= '0; m_b <= '0; m_op <= '0;
    end else begin
      if (age >= 4 && rsp_ready && m_cnt < CMAX) m_cnt <= m_cnt + 1;
      if (req_valid && m_ready) begin
        age <= 1; m_a <= req_a; m_b <= req_b; m_op <= req_opcode;
        m_rsp <= golden(req_a, req_b, req_opcode, zero_bad);
      end else if (age >= 1 && age < 4) age <= age + 1;
      else if (age >= 4 && rsp_ready) age <= -1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", req_ready, m_ready);
      chk("rsp_valid", rsp_valid, age >= 4);
      chk("alu_clk_en", alu_clk_en, (age == 1 || age == 2));
      chk("alu_a", alu_a, m_a);
      chk("alu_b", alu_b, m_b);
      chk("alu_opcode", alu_opcode, m_op);
      chk("op_count", op_count, m_cnt);
      if (age >= 4) chk("rsp_fields", {rsp_result, rsp_carry, rsp_zero, rsp_err}, m_rsp);
    end
  end

  task automatic send(input logic [DW-1:0] a, b, input logic [2:0] op, output int lat, output int en);
    int n;
    @(posedge clk); #1;
    req_a = a; req_b = b; req_opcode = op; req_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0; en = 0;
    do begin
      @(negedge clk); lat++;
      if (alu_clk_en) en++;
    end while (!rsp_valid && lat < 50);
    if (lat >= 50) chk("rsp_timeout", 0, 1);
  endtask

  initial begin
    int lat, en, c0;
    logic [DW-1:0] r0;
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    chk("reset_outs", {rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_err, alu_a, alu_b,
                       alu_opcode, alu_clk_en, op_count}, 0);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", req_ready, 1);

    send(8'h05, 8'h05, 3'b001, lat, en);
    chk("sub_fields", {rsp_result, rsp_carry, rsp_zero, rsp_err}, {8'h00, 3'b010});
    @(negedge clk);
    chk("sub_count", op_count, 1);

    send(8'hF0, 8'h20, 3'b000, lat, en);
    chk("add_latency", lat, 4);
    chk("add_clk_en_cycles", en, 2);
    chk("add_fields", {rsp_result, rsp_carry, rsp_zero, rsp_err}, {8'h10, 3'b100});

    send(8'hFF, 8'h01, 3'b000, lat, en);
    chk("add_wrap_fields", {rsp_result, rsp_carry, rsp_zero}, {8'h00, 2'b11});
    send(8'h0F, 8'hF0, 3'b010, lat, en);
    chk("and_masked_fields", {rsp_result, rsp_carry, rsp_zero}, {8'h00, 2'b01});

    @(posedge clk); #1 rsp_ready = 1'b0;
    send(8'h0C, 8'h30, 3'b011, lat, en);
    chk("or_result", rsp_result, 8'h3C);
    r0 = rsp_result; c0 = op_count;
    @(posedge clk); #1;
    req_a = 8'hAA; req_b = 8'h55; req_opcode = 3'b100; req_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("hold_ready", req_ready, 0);
      chk("hold_clk_en", alu_clk_en, 0);
      chk("hold_result", {rsp_valid, rsp_result}, {1'b1, r0});
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    chk("same_cycle_ready", req_ready, 1);
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    chk("issue_after_accept", {alu_clk_en, rsp_valid, alu_a}, {2'b10, 8'hAA});
    chk("hold_count_once", op_count, c0 + 1);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 50);
    chk("xor_fields", {rsp_result, rsp_carry}, {8'hFF, 1'b0});

    @(posedge clk); #1 zero_bad = 1'b1;
    send(8'h05, 8'h05, 3'b001, lat, en);
    chk("err_fields", {rsp_result, rsp_zero, rsp_err}, {8'h00, 2'b01});
    @(posedge clk); #1 zero_bad = 1'b0;

    req_a = 8'h11; req_b = 8'h22; req_opcode = 3'b000; req_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("midop_reset_outs", {rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_err, alu_a, alu_b,
                             alu_opcode, alu_clk_en, op_count}, 0);
    repeat (6) begin @(negedge clk); chk("no_rsp_after_reset", rsp_valid, 0); end
    send(8'h03, 8'h01, 3'b100, lat, en);
    chk("xor_after_reset", rsp_result, 8'h02);

    repeat (400) begin
      @(posedge clk); #1;
      req_valid  = 1'($urandom_range(0, 1));
      rsp_ready  = ($urandom_range(0, 3) != 0);
      req_a      = 8'($urandom);
      req_b      = 8'($urandom);
      req_opcode = 3'($urandom);
    end
    @(posedge clk); #1 req_valid = 1'b0; rsp_ready = 1'b1;
    repeat (8) @(negedge clk);
    chk("count_saturated", op_count, CMAX);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
